// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states and access checks.
// Helper functions are pure combinational and evaluate the request currently on the core port.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  // Stores have no signed/unsigned variants, so only B/H/W are legal for them.
  function automatic logic size_legal(input logic we, input logic [2:0] size);
    logic ok;
    if (we) ok = (size == LDST_B) || (size == LDST_H) || (size == LDST_W);
    else    ok = (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
                 (size == LDST_BU) || (size == LDST_HU);
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      LDST_H, LDST_HU: bad = offset[0];
      LDST_W:          bad = (offset != 2'b00);
      default:         bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data alignment: selects the addressed byte/halfword of a memory word and sign/zero-extends it.
// Purely combinational, no state and no flow control.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] rd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = mem_rd[7:0];
      2'd1:    byte_sel = mem_rd[15:8];
      2'd2:    byte_sel = mem_rd[23:16];
      default: byte_sel = mem_rd[31:24];
    endcase
    half_sel = offset[1] ? mem_rd[31:16] : mem_rd[15:0];

    case (size)
      LDST_B:  rd = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: rd = {24'h0, byte_sel};
      LDST_H:  rd = {{16{half_sel[15]}}, half_sel};
      LDST_HU: rd = {16'h0, half_sel};
      default: rd = mem_rd;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns core accesses into one word-aligned ext_mem request and returns extended load data.
// Core stalls from the request cycle until mem_ready_i; misaligned/illegal accesses only pulse an error flag.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q;
  logic [1:0]  offset_q;
  logic [2:0]  size_q;

  logic        idle_req;
  logic        bad_size;
  logic        bad_align;
  logic        issue;
  logic [31:0] ext_rd;

  assign bad_size  = !size_legal(core_we_i, core_size_i);
  assign bad_align = !bad_size && misaligned(core_size_i, core_addr_i[1:0]);

  // Gated by rst_ni so a core holding core_req_i through reset cannot launch an access.
  assign idle_req = rst_ni && (state_q == IDLE) && core_req_i;
  assign issue    = idle_req && !bad_size && !bad_align;

  assign illegal_o    = idle_req && bad_size;
  assign misalign_o   = idle_req && bad_align;
  assign mem_req_o    = issue;
  assign mem_we_o     = issue && core_we_i;
  assign mem_addr_o   = core_addr_i;
  assign core_stall_o = issue || ((state_q == WAIT) && !mem_ready_i);

  always_comb begin
    mem_be_o = 4'hF;
    mem_wd_o = core_wd_i;
    if (core_we_i) begin
      case (core_size_i)
        LDST_B: begin
          mem_be_o = 4'b0001 << core_addr_i[1:0];
          mem_wd_o = {4{core_wd_i[7:0]}};
        end
        LDST_H: begin
          mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
          mem_wd_o = {2{core_wd_i[15:0]}};
        end
        default: begin
          mem_be_o = 4'hF;
          mem_wd_o = core_wd_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      offset_q <= 2'b00;
      size_q   <= LDST_B;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q  <= WAIT;
            offset_q <= core_addr_i[1:0];
            size_q   <= core_size_i;
          end
        end
        WAIT: begin
          if (mem_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  lsu_load_ext u_load_ext (
    .mem_rd (mem_rd_i),
    .offset (offset_q),
    .size   (size_q),
    .rd     (ext_rd)
  );

  // Memory read data is only meaningful in the response cycle; hold the result at zero otherwise.
  assign core_rd_o = ((state_q == WAIT) && mem_ready_i) ? ext_rd : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random core accesses against a byte-addressed memory model,
// with memory-side and core-side monitors popping expectations from scoreboard queues.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    bit          is_load;
    logic [31:0] rd;
  } rsp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        misalign_o;
  logic        illegal_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_checks   = 0;
  int n_fail     = 0;
  int req_cnt    = 0;
  int n_issued   = 0;
  int next_delay = 0;

  req_t       req_q[$];
  rsp_t       rsp_q[$];
  logic [1:0] err_q[$];

  logic [7:0] ref_mem [512];
  logic [7:0] dut_mem [512];

  lsu_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .illegal_o    (illegal_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event observed or bound expired, required not to happen", name);
  endtask

  // Memory side: checks each request against the scoreboard, then answers after next_delay wait cycles.
  initial begin
    int          resp_wait;
    logic        resp_pend;
    logic [31:0] resp_data;
    req_t        e;
    logic [8:0]  base;
    resp_wait   = 0;
    resp_pend   = 1'b0;
    resp_data   = 32'h0;
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        resp_pend = 1'b0;
      end else if (mem_req_o) begin
        req_cnt++;
        if (req_q.size() == 0) begin
          flag_fail("unexpected_mem_req");
        end else begin
          e = req_q.pop_front();
          chk("mem_we", 32'(mem_we_o), 32'(e.we));
          chk("mem_be", 32'(mem_be_o), 32'(e.be));
          chk("mem_addr", mem_addr_o, e.addr);
          if (e.we) chk("mem_wd", mem_wd_o, e.wd);
        end
        base = {mem_addr_o[8:2], 2'b00};
        if (mem_we_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) dut_mem[base + 9'(b)] = mem_wd_o[8*b +: 8];
        end
        resp_data = {dut_mem[base + 9'd3], dut_mem[base + 9'd2], dut_mem[base + 9'd1], dut_mem[base]};
        resp_pend = 1'b1;
        resp_wait = next_delay;
      end
      @(posedge clk_i);
      #1;
      if (resp_pend) begin
        mem_rd_i    = resp_data;
        mem_ready_i = (resp_wait == 0);
        if (resp_wait == 0) resp_pend = 1'b0;
        else resp_wait--;
      end else begin
        mem_ready_i = 1'b0;
        mem_rd_i    = $urandom;
      end
    end
  end

  // Core side: error pulses, load results on completion, and zero read data at all other times.
  initial begin
    bit   in_wait;
    rsp_t r;
    in_wait = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        in_wait = 1'b0;
      end else begin
        if (misalign_o || illegal_o) begin
          if (err_q.size() == 0) flag_fail("unexpected_error_pulse");
          else chk("error_code", 32'({illegal_o, misalign_o}), 32'(err_q.pop_front()));
          chk("error_no_mem_req", 32'(mem_req_o), 32'd0);
          chk("error_no_stall", 32'(core_stall_o), 32'd0);
        end
        if (in_wait && !core_stall_o) begin
          if (rsp_q.size() == 0) begin
            flag_fail("unexpected_completion");
          end else begin
            r = rsp_q.pop_front();
            if (r.is_load) chk("load_data", core_rd_o, r.rd);
          end
          in_wait = 1'b0;
        end else begin
          chk("rd_zero_when_idle", core_rd_o, 32'h0);
          if (mem_req_o) in_wait = 1'b1;
        end
      end
    end
  end

  // Reference model: byte-addressed memory, accesses of 1<<size[1:0] little-endian bytes.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int delay);
    bit          legal;
    bit          mis;
    int          nb;
    int          stalls;
    int          req0;
    req_t        e;
    rsp_t        r;
    logic [31:0] v;
    legal = we ? (size == LDST_B || size == LDST_H || size == LDST_W)
               : (size == LDST_B || size == LDST_H || size == LDST_W ||
                  size == LDST_BU || size == LDST_HU);
    nb  = 1 << size[1:0];
    mis = legal && ((addr % 32'(nb)) != 32'd0);
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    if (!legal || mis) begin
      err_q.push_back(legal ? 2'b01 : 2'b10);
      core_req_i = 1'b1;
      @(negedge clk_i);
      chk("reject_no_stall", 32'(core_stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      core_req_i = 1'b0;
      return;
    end
    e.we   = we;
    e.addr = addr;
    e.be   = 4'hF;
    e.wd   = wd;
    if (we) begin
      if (nb == 1) begin
        e.be = 4'(1 << addr[1:0]);
        e.wd = 32'(wd[7:0]) * 32'h0101_0101;
      end else if (nb == 2) begin
        e.be = 4'(3 << addr[1:0]);
        e.wd = 32'(wd[15:0]) * 32'h0001_0001;
      end
      for (int i = 0; i < nb; i++) ref_mem[9'(addr + 32'(i))] = wd[8*i +: 8];
      r.is_load = 1'b0;
      r.rd      = 32'h0;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[9'(addr + 32'(i))];
      if (size == LDST_B && v[7])  v[31:8]  = 24'hFF_FFFF;
      if (size == LDST_H && v[15]) v[31:16] = 16'hFFFF;
      r.is_load = 1'b1;
      r.rd      = v;
    end
    req_q.push_back(e);
    rsp_q.push_back(r);
    n_issued++;
    next_delay = delay;
    req0       = req_cnt;
    core_req_i = 1'b1;
    stalls     = 0;
    forever begin
      @(negedge clk_i);
      if (!core_stall_o) break;
      stalls++;
      if (stalls > 40) begin
        flag_fail("stall_timeout");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    core_req_i = 1'b0;
    chk("stall_cycles", 32'(stalls), 32'(1 + delay));
    chk("mem_req_per_access", 32'(req_cnt - req0), 32'd1);
  endtask

  initial begin
    logic        w;
    logic [2:0]  sz;
    logic [31:0] ad;
    int          dl;
    rst_ni      = 1'b0;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = LDST_W;
    core_addr_i = 32'h102;
    core_wd_i   = 32'h0;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 8'($urandom);
      dut_mem[i] = ref_mem[i];
    end
    ref_mem[256] = 8'h01; ref_mem[257] = 8'h7F; ref_mem[258] = 8'hF0; ref_mem[259] = 8'h80;
    for (int i = 256; i < 260; i++) dut_mem[i] = ref_mem[i];

    // Reset state, with a misaligned request held on the core port.
    #3;
    chk("reset_stall", 32'(core_stall_o), 32'd0);
    chk("reset_mem_req", 32'(mem_req_o), 32'd0);
    chk("reset_misalign", 32'(misalign_o), 32'd0);
    chk("reset_illegal", 32'(illegal_o), 32'd0);
    chk("reset_rd", core_rd_o, 32'h0);
    core_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset while waiting on memory abandons the access immediately.
    req_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h100, wd: 32'h0});
    next_delay  = 50;
    core_we_i   = 1'b0;
    core_size_i = LDST_W;
    core_addr_i = 32'h100;
    core_req_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("wait_stall_held", 32'(core_stall_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset_stall", 32'(core_stall_o), 32'd0);
    chk("midreset_mem_req", 32'(mem_req_o), 32'd0);
    core_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    access(1'b0, LDST_B,  32'h100, 32'h0, 0);
    access(1'b0, LDST_B,  32'h103, 32'h0, 1);
    access(1'b0, LDST_BU, 32'h103, 32'h0, 0);
    access(1'b0, LDST_H,  32'h102, 32'h0, 2);
    access(1'b0, LDST_HU, 32'h102, 32'h0, 0);
    access(1'b1, LDST_B,  32'h103, 32'h0000_00A5, 0);
    access(1'b0, LDST_W,  32'h100, 32'h0, 0);
    access(1'b0, LDST_W,  32'h102, 32'h0, 0);
    access(1'b1, LDST_H,  32'h101, 32'h1234, 0);
    access(1'b1, 3'd4,    32'h100, 32'h1, 0);
    access(1'b0, 3'd3,    32'h100, 32'h0, 0);
    access(1'b0, 3'd7,    32'h101, 32'h0, 0);
    access(1'b0, LDST_W,  32'h100, 32'h0, 3);
    access(1'b1, LDST_W,  32'h40, 32'h1234_5678, 0);
    access(1'b0, LDST_W,  32'h40, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0:       sz = LDST_B;
          1:       sz = LDST_H;
          2:       sz = LDST_W;
          3:       sz = LDST_BU;
          default: sz = LDST_HU;
        endcase
        if (w && sz[2]) sz = {1'b0, sz[1:0]};
      end
      ad = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz[1:0]) - 32'd1);
      dl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      access(w, sz, ad, $urandom, dl);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end

    repeat (4) @(negedge clk_i);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("err_queue_drained", 32'(err_q.size()), 32'd0);
    chk("total_mem_reqs", 32'(req_cnt), 32'(n_issued + 1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
